spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
- Parametrised SPI slave front end for the single-port RAM wrapper.
- Deserialises MOSI command frames of DATA_W+2 bits (2 command bits + DATA_W payload) and presents them on rx_data/rx_valid.
- For read-data commands, accepts the RAM response on tx_data/tx_valid and serialises it on MISO.
- Adds frame-abort and response-timeout detection, reported on frame_err.

Parameters:
- DATA_W, 8: payload width in bits; rx_data is DATA_W+2 bits wide, tx_data is DATA_W bits wide.
- TX_TIMEOUT, 16: maximum number of cycles spent waiting for tx_valid after a read-data frame. Legal range is 1 to 255.

Ports:
- clk, input, 1: system clock; also the SPI bit clock, one bit per cycle.
- rst_n, input, 1: reset, synchronous, active-low.
- SS_n, input, 1: slave select, active-low.
- MOSI, input, 1: serial in, MSB first.
- MISO, output, 1: serial out, MSB first.
- rx_data, output, DATA_W+2: last completed frame; bits [DATA_W+1:DATA_W] are the command, bits [DATA_W-1:0] are the payload.
- rx_valid, output, 1: one-cycle pulse when rx_data updates.
- tx_data, input, DATA_W: read data from RAM.
- tx_valid, input, 1: tx_data is valid and is latched on the cycle it is sampled high.
- frame_err, output, 1: one-cycle pulse on abort or timeout.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, rd_addr_pending=0, all counters and shift registers cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay in IDLE.
- CHK_CMD: samples MOSI as frame bit DATA_W+1 and loads it into the shift register.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_pending=0 -> READ_ADD.
  - MOSI=1 and rd_addr_pending=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift in the remaining DATA_W+1 bits, one per cycle, MSB first.
- Frame completion: on the edge that samples the last bit, rx_data is loaded with the full frame and rx_valid=1 for exactly that following cycle.
  - Full frame sampled over DATA_W+2 consecutive cycles, starting with the CHK_CMD cycle.
  - Next-state selection on completion:
    - WRITE -> DONE.
    - READ_ADD -> DONE, rd_addr_pending set to 1.
    - READ_DATA -> TX_WAIT, wait counter cleared.
  - State selection uses only the first bit and rd_addr_pending. The second command bit passes through in rx_data unchecked.
- TX_WAIT:
  - tx_valid=1 -> latch tx_data, go to TX_SHIFT.
  - Otherwise increment the wait counter. After TX_TIMEOUT cycles without tx_valid: frame_err pulses 1 cycle, rd_addr_pending cleared, go to DONE, no data is driven on MISO.
- TX_SHIFT: MISO = latched[DATA_W-1] in the first cycle, down to latched[0] in cycle DATA_W. Then go to DONE and clear rd_addr_pending.
- MISO=0 in every state except TX_SHIFT.
- DONE: ignores MOSI; SS_n=1 -> IDLE.
- SS_n=1 in any state other than IDLE or DONE returns to IDLE on the next edge.
  - If this happens in CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT or TX_SHIFT: frame_err pulses 1 cycle, no rx_valid is generated, rx_data is unchanged, and MISO goes to 0 immediately.
  - rd_addr_pending is unchanged by an abort.
- Simultaneous events:
  - Frame completion and SS_n rising on the same edge: the frame counts as complete (rx_valid pulses), then the state goes to IDLE.
  - tx_valid during states other than TX_WAIT is ignored.
- rd_addr_pending persists across frames; only reset, a completed read-data transfer, or a timeout clears it.
- Bit counter is $clog2(DATA_W+2) bits wide; the wait counter is 8 bits wide.
- Back-to-back frames: IDLE must see SS_n=0 again, so at least one cycle of SS_n=1 is required between frames.

Test Plan:
- Write frame, DATA_W=8: reset, SS_n=0, shift 10'b00_1010_0101 -> rx_data=10'h0A5 with rx_valid high for exactly 1 cycle, 11 cycles after SS_n falls; MISO stays 0.
- Read address then read data: frame 10'b10_0000_0011 -> rx_valid, rd_addr_pending=1. Next frame 10'b11_xxxx_xxxx, tx_valid=1 with tx_data=8'hC3 two cycles after rx_valid -> MISO outputs 1,1,0,0,0,0,1,1 on consecutive cycles, then rd_addr_pending=0.
- Abort: raise SS_n after 5 bits of a write -> frame_err 1-cycle pulse, no rx_valid, rx_data holds its previous value, state returns to IDLE.
- Timeout, TX_TIMEOUT=4: read-data frame with tx_valid held 0 -> frame_err pulses 4 cycles after rx_valid, MISO remains 0, a following 1-leading frame goes to READ_ADD.
- Synchronous reset during TX_SHIFT, after 3 bits -> MISO=0 and state IDLE at the next edge; rd_addr_pending=0 and rx_data=0.
- Parameter sweep, DATA_W=16: repeat the write and read scenarios -> 18-bit rx_data and 16 MISO bits, values checked against the expected frames.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave front end: frame deserialiser, read-data serialiser, abort/timeout detect
module spi_slave_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W+1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              pending_q, pending_d;

  logic rx_state, last_bit, abort, timeout, tx_last;

  // A frame whose final bit lands together with SS_n rising still completes, so it is not an abort.
  always_comb begin
    rx_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    last_bit = rx_state && (bit_cnt_q == RX_LAST);
    abort    = SS_n && !last_bit &&
               (state_q inside {CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT});
    timeout  = (state_q == TX_WAIT) && !SS_n && !tx_valid && (wait_cnt_q == WAIT_LAST);
    tx_last  = (state_q == TX_SHIFT) && (bit_cnt_q == TX_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)           state_d = IDLE;
        else if (!MOSI)     state_d = WRITE;
        else if (pending_q) state_d = READ_DATA;
        else                state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (last_bit) begin
          if (SS_n)                        state_d = IDLE;
          else if (state_q == READ_DATA)   state_d = TX_WAIT;
          else                             state_d = DONE;
        end else if (SS_n) begin
          state_d = IDLE;
        end
      end
      TX_WAIT: begin
        if (SS_n)          state_d = IDLE;
        else if (tx_valid) state_d = TX_SHIFT;
        else if (timeout)  state_d = DONE;
      end
      TX_SHIFT: begin
        if (SS_n)         state_d = IDLE;
        else if (tx_last) state_d = DONE;
      end
      DONE:     if (SS_n) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // SS_n gates MISO directly so the line drops in the same cycle the master deselects.
  always_comb begin
    MISO = 1'b0;
    if ((state_q == TX_SHIFT) && !SS_n) MISO = tx_shift_q[DATA_W-1];
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    pending_d   = pending_q;
    rx_valid_d  = 1'b0;
    frame_err_d = abort || timeout;
    case (state_q)
      CHK_CMD: begin
        rx_shift_d = {{DATA_W{1'b0}}, MOSI};
        bit_cnt_d  = '0;
      end
      WRITE, READ_ADD, READ_DATA: begin
        rx_shift_d = {rx_shift_q[DATA_W-1:0], MOSI};
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        if (last_bit) begin
          rx_data_d  = {rx_shift_q, MOSI};
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          if (state_q == READ_ADD) pending_d = 1'b1;
        end
      end
      TX_WAIT: begin
        if (!SS_n) begin
          if (tx_valid) begin
            tx_shift_d = tx_data;
            bit_cnt_d  = '0;
          end else if (timeout) begin
            pending_d = 1'b0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      TX_SHIFT: begin
        if (!SS_n) begin
          tx_shift_d = tx_shift_q << 1;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (tx_last) pending_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      pending_q   <= pending_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
